// File: rtl/dutif_capture_pkg.sv
// rtl/dutif_capture_pkg.sv - shared register map, FSM encoding and helpers for dutif_capture
//
// Purpose:
//   Register addresses, capture FSM state encoding and bit positions shared
//   by the capture core and its bench.
// Ports:
//   none (package)

package dutif_capture_pkg;

    // Register addresses (wb_addr)
    localparam logic [3:0] REG_CSR  = 4'd0;
    localparam logic [3:0] REG_TRIG = 4'd1;
    localparam logic [3:0] REG_DIV  = 4'd2;
    localparam logic [3:0] REG_POST = 4'd3;
    localparam logic [3:0] REG_DATA = 4'd4;
    localparam logic [3:0] REG_PTR  = 4'd5;

    // CSR write bits
    localparam int CSR_ARM_BIT   = 0;
    localparam int CSR_ABORT_BIT = 1;

    // TRIG edge-mode bit (only live when edge triggering is built in)
    localparam int TRIG_EDGE_BIT = 16;

    // Capture FSM; the encoding is visible to the host in CSR[1:0]
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } cap_state_t;

    // Sample counter stops at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dutif_capture_ram.sv
// rtl/dutif_capture_ram.sv - sample buffer, simple dual-port RAM with registered read
//
// Purpose:
//   2^AW x DW sample store. One synchronous write port for the capture
//   engine, one registered read port for the host (one cycle of latency).
//   No reset so it maps onto block RAM.
// Ports:
//   clk    in   1   clock
//   we     in   1   write enable
//   waddr  in   AW  write address
//   wdata  in   DW  write data
//   raddr  in   AW  read address
//   rdata  out  DW  registered read data (mem[raddr] of the previous cycle)

module dutif_capture_ram #(
    parameter int DW = 8,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dutif_capture.sv
// rtl/dutif_capture.sv - Wishbone logic analyzer capturing synchronized DUT pins into a ring buffer
//
// Purpose:
//   Samples the synchronized sense vector at a divided rate into a ring
//   buffer while armed, fires on a masked pattern, stores POST further
//   samples and freezes. The host reads the buffer and pointers over a
//   small Wishbone slave port.
// Ports:
//   clk       in   1     system clock
//   rst       in   1     asynchronous reset, active-high
//   sense     in   DW    raw DUT pins (asynchronous, 2-FF synchronized here)
//   wb_addr   in   4     register address
//   wb_rdata  out  32    read data, zero outside the ack cycle
//   wb_wdata  in   32    write data
//   wb_we     in   1     write enable
//   wb_cyc    in   1     cycle request, held until ack
//   wb_ack    out  1     one-cycle acknowledge, two cycles after cyc rises
// Build option:
//   DUTIF_CAPTURE_EDGE_TRIG_EN - adds edge-qualified triggering via TRIG[16].
//   Without it TRIG[16] reads 0 and triggering is level-match only.

module dutif_capture
    import dutif_capture_pkg::*;
#(
    parameter int DW        = 8,
    parameter int AW        = 9,
    parameter int DIV_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sense,
    input  logic [3:0]    wb_addr,
    output logic [31:0]   wb_rdata,
    input  logic [31:0]   wb_wdata,
    input  logic          wb_we,
    input  logic          wb_cyc,
    output logic          wb_ack
);

    // ------------------------------------------------------------------
    // Pin synchronizer
    // ------------------------------------------------------------------
    logic [DW-1:0] sync1;
    logic [DW-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sense;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Bus-side registers
    // ------------------------------------------------------------------
    logic                 bus_pend;     // cycle accepted, RAM read in flight
    logic [DW-1:0]        trig_mask;
    logic [DW-1:0]        trig_value;
    logic [DIV_WIDTH-1:0] div_val;
    logic [AW-1:0]        post_val;
    logic [AW-1:0]        rd_ptr;
    logic [31:0]          read_mux;

`ifdef DUTIF_CAPTURE_EDGE_TRIG_EN
    logic                 edge_mode;
`endif

    // Capture-side state
    cap_state_t           state;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        trig_ptr;
    logic [AW-1:0]        post_cnt;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [15:0]          stored_cnt;
    logic [DW-1:0]        ram_q;

`ifdef DUTIF_CAPTURE_EDGE_TRIG_EN
    logic [DW-1:0]        prev_sample;
    logic                 prev_valid;
`endif

    // The register access commits on the same edge that raises ack
    logic commit;
    logic csr_wr;
    logic do_abort;
    logic do_arm;

    assign commit   = bus_pend;
    assign csr_wr   = commit && wb_we && (wb_addr == REG_CSR);
    assign do_abort = csr_wr && wb_wdata[CSR_ABORT_BIT];
    assign do_arm   = csr_wr && wb_wdata[CSR_ARM_BIT] && !wb_wdata[CSR_ABORT_BIT];

    logic unused_wdata;
    assign unused_wdata = ^wb_wdata[31:16];

    always_comb begin
        read_mux = '0;
        case (wb_addr)
            REG_CSR: begin
                read_mux[1:0]   = state;
                read_mux[31:16] = stored_cnt;
            end
            REG_TRIG: begin
                read_mux[DW-1:0]   = trig_mask;
                read_mux[DW+7:8]   = trig_value;
`ifdef DUTIF_CAPTURE_EDGE_TRIG_EN
                read_mux[TRIG_EDGE_BIT] = edge_mode;
`endif
            end
            REG_DIV:  read_mux[DIV_WIDTH-1:0] = div_val;
            REG_POST: read_mux[AW-1:0]        = post_val;
            REG_DATA: read_mux[DW-1:0]        = ram_q;
            REG_PTR: begin
                read_mux[AW-1:0]   = trig_ptr;
                read_mux[AW+15:16] = wr_ptr;
            end
            default: read_mux = '0;
        endcase
    end

    // Bus handshake: accept -> (RAM read cycle) -> ack -> drop.
    // The data path already presents buffer[rd_ptr] on ram_q by the
    // commit edge because rd_ptr only moves on commit edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_pend   <= 1'b0;
            wb_ack     <= 1'b0;
            wb_rdata   <= '0;
            trig_mask  <= '0;
            trig_value <= '0;
            div_val    <= '0;
            post_val   <= '0;
            rd_ptr     <= '0;
`ifdef DUTIF_CAPTURE_EDGE_TRIG_EN
            edge_mode  <= 1'b0;
`endif
        end else if (wb_ack) begin
            wb_ack   <= 1'b0;
            wb_rdata <= '0;
        end else if (bus_pend) begin
            bus_pend <= 1'b0;
            wb_ack   <= 1'b1;
            wb_rdata <= read_mux;
            if (wb_we) begin
                case (wb_addr)
                    REG_TRIG: begin
                        trig_mask  <= wb_wdata[DW-1:0];
                        trig_value <= wb_wdata[DW+7:8];
`ifdef DUTIF_CAPTURE_EDGE_TRIG_EN
                        edge_mode  <= wb_wdata[TRIG_EDGE_BIT];
`endif
                    end
                    REG_DIV:  div_val  <= wb_wdata[DIV_WIDTH-1:0];
                    REG_POST: post_val <= wb_wdata[AW-1:0];
                    REG_PTR:  rd_ptr   <= wb_wdata[AW-1:0];
                    default: ;
                endcase
            end else if (wb_addr == REG_DATA) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end else if (wb_cyc) begin
            bus_pend <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sample-rate divider and trigger detection
    // ------------------------------------------------------------------
    logic tick;
    logic capturing;
    logic trig_hit;
    logic ram_we;
    logic [AW-1:0] post_next;

    // >= rather than == so a DIV lowered below the running count
    // recovers on the next clock instead of waiting for a full wrap.
    assign tick      = (div_cnt >= div_val);
    assign capturing = (state == ST_ARMED) || (state == ST_POST);
    assign post_next = post_cnt + AW'(1);

`ifdef DUTIF_CAPTURE_EDGE_TRIG_EN
    // Edge mode also needs at least one masked bit to have changed since
    // the previous stored sample; the first tick after arm has no history.
    assign trig_hit = (((sync2 ^ trig_value) & trig_mask) == '0) &&
                      (!edge_mode ||
                       (prev_valid && (((sync2 ^ prev_sample) & trig_mask) != '0)));
`else
    assign trig_hit = (((sync2 ^ trig_value) & trig_mask) == '0);
`endif

    // Arm/abort edges never store a sample, even if a tick lands on them
    assign ram_we = tick && capturing && !do_arm && !do_abort;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            trig_ptr   <= '0;
            post_cnt   <= '0;
            div_cnt    <= '0;
            stored_cnt <= '0;
`ifdef DUTIF_CAPTURE_EDGE_TRIG_EN
            prev_sample <= '0;
            prev_valid  <= 1'b0;
`endif
        end else begin
            if (do_arm || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_WIDTH'(1);
            end

            if (do_abort) begin
                state <= ST_IDLE;
            end else if (do_arm) begin
                state      <= ST_ARMED;
                wr_ptr     <= '0;
                stored_cnt <= '0;
                post_cnt   <= '0;
`ifdef DUTIF_CAPTURE_EDGE_TRIG_EN
                prev_valid <= 1'b0;
`endif
            end else if (ram_we) begin
                wr_ptr     <= wr_ptr + AW'(1);
                stored_cnt <= sat_inc16(stored_cnt);
`ifdef DUTIF_CAPTURE_EDGE_TRIG_EN
                prev_sample <= sync2;
                prev_valid  <= 1'b1;
`endif
                if (state == ST_ARMED) begin
                    if (trig_hit) begin
                        trig_ptr <= wr_ptr;
                        post_cnt <= '0;
                        state    <= (post_val == '0) ? ST_DONE : ST_POST;
                    end
                end else begin
                    post_cnt <= post_next;
                    if (post_next == post_val) begin
                        state <= ST_DONE;
                    end
                end
            end
        end
    end

    dutif_capture_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (sync2),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

endmodule
